alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 118 +++++++++++
 tb/tb_alu_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake, {N,V,C,Z} flags, an internal
// accumulator usable as operand A, and a sticky signed-overflow flag.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             ovf_sticky
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [SHW-1:0]   amt;
  logic             v_c;
  logic             c_c;
  logic             accept;

  // The only combinational path to an output: out_ready -> in_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign a_eff = use_acc ? acc : a;
  assign amt   = b[SHW-1:0];
  assign sum   = {1'b0, a_eff} + {1'b0, b};
  assign diff  = {1'b0, a_eff} - {1'b0, b};

  // One guard bit beyond the word catches the last bit shifted out; it is 0
  // for a zero shift and for amounts past WIDTH, which also zero the result.
  assign shl_ext = {1'b0, a_eff} << amt;
  assign shr_ext = {a_eff, 1'b0} >> amt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value held, which would infer a latch.
    res_c = '0;
    v_c   = 1'b0;
    c_c   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        v_c   = (a_eff[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff[WIDTH-1:0];
        c_c   = diff[WIDTH];
        v_c   = (a_eff[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_SHL: begin
        res_c = shl_ext[WIDTH-1:0];
        c_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_ext[WIDTH:1];
        c_c   = shr_ext[0];
      end
      OP_AND:  res_c = a_eff & b;
      OP_OR:   res_c = a_eff | b;
      OP_XOR:  res_c = a_eff ^ b;
      OP_EQ:   res_c = {{(WIDTH-1){1'b0}}, (a_eff == b)};
      default: res_c = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      flags      <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      result     <= res_c;
      flags      <= {res_c[WIDTH-1], v_c, c_c, (res_c == '0)};
      acc        <= res_c;
      // A simultaneous clear wins over the old sticky value, not over this op's V.
      ovf_sticky <= (ovf_sticky & ~clr) | v_c;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clr) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: an 8-bit instance for most vectors and a
// 16-bit instance for the wider subtract and modulo shift amount.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, use_acc, clr, out_valid, out_ready, ovf_sticky;
  logic [7:0]  a, b, result;
  logic [2:0]  op;
  logic [3:0]  flags;

  logic        in_valid16, in_ready16, out_valid16, ovf_sticky16;
  logic [15:0] a16, b16, result16;
  logic [2:0]  op16;
  logic [3:0]  flags16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .ovf_sticky(ovf_sticky)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .use_acc(1'b0), .clr(1'b0),
    .out_valid(out_valid16), .out_ready(1'b1), .result(result16),
    .flags(flags16), .ovf_sticky(ovf_sticky16)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op = '0; use_acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst flags", flags, 0);
    check("rst sticky", ovf_sticky, 0);
    check("rst in_ready", in_ready, 1);
    rst_n = 1'b1;
    #5;

    // Add with carry-out to zero, then signed overflow.
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; op = 3'b000;
    step();
    check("add ff+1 valid", out_valid, 1);
    check("add ff+1 result", result, 8'h00);
    check("add ff+1 flags", flags, 4'b0011);
    a = 8'h7F; b = 8'h01;
    step();
    check("add 7f+1 result", result, 8'h80);
    check("add 7f+1 flags", flags, 4'b1100);
    check("add 7f+1 sticky", ovf_sticky, 1);

    // Shifts with amount 9 mod 8 = 1, and equality compare.
    a = 8'h81; b = 8'h09; op = 3'b010;
    step();
    check("shl result", result, 8'h02);
    check("shl flags", flags, 4'b0010);
    op = 3'b011;
    step();
    check("shr result", result, 8'h40);
    check("shr flags", flags, 4'b0010);
    a = 8'h5A; b = 8'h5A; op = 3'b111;
    step();
    check("eq result", result, 8'h01);
    check("eq flags", flags, 4'b0000);
    check("eq sticky held", ovf_sticky, 1);

    // Clear without accept, then a bubble-free accumulator chain.
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr out_valid drained", out_valid, 0);
    check("clr sticky", ovf_sticky, 0);
    in_valid = 1'b1; use_acc = 1'b1; op = 3'b000; a = 8'hEE; b = 8'd3;
    step();
    check("acc chain 1", result, 8'd3);
    check("acc chain 1 valid", out_valid, 1);
    b = 8'd5;
    step();
    check("acc chain 2", result, 8'd8);
    b = 8'd7;
    step();
    check("acc chain 3", result, 8'd15);
    check("acc chain 3 valid", out_valid, 1);

    // Backpressure: hold result 0x30 for 4 cycles, then drain and accept together.
    use_acc = 1'b0; a = 8'h10; b = 8'h20; op = 3'b101;
    step();
    check("or result", result, 8'h30);
    out_ready = 1'b0; a = 8'hAA; b = 8'h0F; op = 3'b110;
    #1;
    check("stall in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall result", result, 8'h30);
      check("stall flags", flags, 4'b0000);
      check("stall out_valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("drain in_ready", in_ready, 1);
    step();
    check("drain+accept result", result, 8'hA5);
    check("drain+accept flags", flags, 4'b1000);
    check("drain+accept valid", out_valid, 1);
    use_acc = 1'b1; b = 8'h00; op = 3'b101;
    step();
    check("acc readback", result, 8'hA5);

    // Reset mid-stall with sticky set.
    use_acc = 1'b0; a = 8'h7F; b = 8'h01; op = 3'b000;
    step();
    check("pre-reset sticky", ovf_sticky, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("pre-reset valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst result", result, 0);
    check("async rst flags", flags, 0);
    check("async rst sticky", ovf_sticky, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; use_acc = 1'b1; op = 3'b101; b = 8'h00; a = 8'h77;
    step();
    check("post-rst acc result", result, 8'h00);
    check("post-rst acc flags", flags, 4'b0001);
    in_valid = 1'b0;

    // 16-bit instance: signed-overflow subtract and shift amount 19 mod 16.
    in_valid16 = 1'b1; a16 = 16'h8000; b16 = 16'h0001; op16 = 3'b001;
    step();
    check("w16 sub result", result16, 16'h7FFF);
    check("w16 sub flags", flags16, 4'b0100);
    check("w16 sub sticky", ovf_sticky16, 1);
    a16 = 16'h0001; b16 = 16'h0013; op16 = 3'b010;
    step();
    check("w16 shl result", result16, 16'h0008);
    check("w16 shl flags", flags16, 4'b0000);
    check("w16 shl valid", out_valid16, 1);
    in_valid16 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
